// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light reaction controller.
package f1_pkg;

    localparam int unsigned LFSR_W = 7;
    localparam int unsigned TIME_W = 16;

    // x^7 + x^6 + 1, maximal length 127, never reaches zero from a non-zero seed
    localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 7'h60;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SEQ,
        DELAY,
        TIMING
    } state_t;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/f1_tick.sv
// Prescaler: one tick every div+1 cycles; clr restarts the count.
module f1_tick
    import f1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [TIME_W-1:0] div,
    output logic              tick
);

    logic [TIME_W-1:0] pcnt;

    // A lowered div leaves pcnt above it; the count then runs on to wrap at all-ones
    assign tick = (pcnt == div);

    // Count up to div, wrap on tick, hold at zero while cleared
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/f1_ctrl.sv
// Start-light sequencer and reaction timer sitting beside the light FSM.
module f1_ctrl
    import f1_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] tick_div,
    input  logic              start,
    input  logic              react,
    input  logic              cmd_seq,
    input  logic              cmd_delay,
    output logic              fsm_trigger,
    output logic              fsm_en,
    output logic              fsm_abort,
    output logic              go,
    output logic              jump_start,
    output logic              react_valid,
    output logic [TIME_W-1:0] react_time,
    output logic              busy
);

    state_t            state;
    state_t            state_nx;
    logic              start_q;
    logic              react_q;
    logic              rst_q;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] dcnt;
    logic [TIME_W-1:0] rcnt;
    logic [TIME_W-1:0] time_r;
    logic              valid_r;
    logic              tick;
    logic              clr;
    logic              start_rise;
    logic              react_rise;
    logic              expire;
    logic              jump;

    assign start_rise = start & ~start_q;
    assign react_rise = react & ~react_q;
    assign expire     = (state == DELAY) && tick && (dcnt == LFSR_W'(1));
    assign jump       = react_rise && (state == ARM || state == SEQ || state == DELAY);

    // The prescaler needs the next state to restart on every transition, so
    // next-state is split out combinationally from the registered FSM below.
    assign clr = (state == IDLE) || (state_nx != state);

    f1_tick u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .div  (tick_div),
        .tick (tick)
    );

    // Next-state decode; react_rise outranks every other transition
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_rise && !rst_q) state_nx = ARM;
            ARM:     state_nx = react_rise ? IDLE : SEQ;
            SEQ: begin
                if (react_rise)              state_nx = IDLE;
                else if (cmd_delay)          state_nx = DELAY;
                else if (tick && !cmd_seq)   state_nx = IDLE;
            end
            DELAY: begin
                if (react_rise)              state_nx = IDLE;
                else if (expire)             state_nx = TIMING;
            end
            TIMING:  if (react_rise) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State, edge detectors, LFSR and the delay/reaction counters.
    // rst_q masks the first post-reset cycle, where start_q reads 0 even if
    // start was held high through reset; this forces a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
            react_q <= 1'b0;
            rst_q   <= 1'b1;
            lfsr    <= LFSR_SEED;
            dcnt    <= '0;
            rcnt    <= '0;
            time_r  <= '0;
            valid_r <= 1'b0;
        end else begin
            state   <= state_nx;
            start_q <= start;
            react_q <= react;
            rst_q   <= 1'b0;
            lfsr    <= lfsr_next(lfsr);
            valid_r <= 1'b0;
            case (state)
                SEQ: begin
                    if (!react_rise && cmd_delay) dcnt <= lfsr;
                end
                DELAY: begin
                    if (tick && dcnt != LFSR_W'(1)) dcnt <= dcnt - 1'b1;
                    if (expire) rcnt <= '0;
                end
                TIMING: begin
                    if (react_rise) begin
                        time_r  <= rcnt;
                        valid_r <= 1'b1;
                    end else if (tick && rcnt != '1) begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fsm_trigger = !rst && (state == ARM);
    assign fsm_en      = !rst && ((state == SEQ && tick && !cmd_delay) || (expire && !react_rise));
    assign go          = !rst && expire && !react_rise;
    assign jump_start  = !rst && jump;
    assign fsm_abort   = !rst && jump;
    assign react_valid = !rst && valid_r;
    assign react_time  = rst ? '0 : time_r;
    assign busy        = !rst && (state != IDLE);

endmodule

// File: doc/f1_ctrl.md
F1_CTRL -- requirements
Module: f1_ctrl

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk is the clock, rst is the reset, with polarity and synchronicity fixed.
REQ-002 Ports SHALL be exactly as follows (name, direction, width, meaning):
  clk  in  1  system clock
  rst  in  1  synchronous active-high reset
  tick_div  in  16  prescaler terminal count N; one tick every N+1 cycles
  start  in  1  start button level; raw, synchronous to clk
  react  in  1  reaction button level; raw, synchronous to clk
  cmd_seq  in  1  from light FSM; sequence in progress
  cmd_delay  in  1  from light FSM; FSM waiting in final-light state
  fsm_trigger  out  1  trigger pulse to light FSM
  fsm_en  out  1  step-enable pulse to light FSM
  fsm_abort  out  1  abort pulse; drives light FSM rst
  go  out  1  one-cycle pulse; lights went out
  jump_start  out  1  one-cycle pulse; react pressed before go
  react_valid  out  1  one-cycle pulse; react_time updated
  react_time  out  16  ticks from go to react press
  busy  out  1  high whenever state is not IDLE

Function
REQ-003 States SHALL be IDLE, ARM, SEQ, DELAY and TIMING, encoded as an enum.
REQ-004 start_rise SHALL be start & ~start_q, and react_rise SHALL be react & ~react_q, where start_q and react_q are the inputs registered one cycle earlier.
REQ-005 The prescaler count pcnt SHALL cover 0..tick_div, and tick SHALL be the combinational term (pcnt == tick_div); pcnt wraps to 0 on tick, so tick_div=0 gives a tick every cycle.
REQ-006 pcnt SHALL clear to 0 on every state change and SHALL hold at 0 in IDLE.
REQ-007 In IDLE, start_rise SHALL move the state to ARM; start_rise in any other state SHALL be ignored.
REQ-008 ARM SHALL last exactly one cycle, and its next state SHALL be SEQ.
REQ-009 fsm_trigger SHALL be the combinational term (state==ARM).
REQ-010 In SEQ, fsm_en SHALL be the combinational term tick & ~cmd_delay.
REQ-011 In SEQ with cmd_delay=1, the block SHALL move to DELAY and load dcnt with the current LFSR value L (1..127).
REQ-012 In DELAY, each tick SHALL decrement dcnt; a tick with dcnt==1 SHALL expire the delay instead, so the delay is exactly L ticks.
REQ-013 On expiry, fsm_en and go SHALL pulse for one cycle, the block SHALL move to TIMING, and rcnt SHALL clear to 0.
REQ-014 In TIMING, each tick SHALL increment rcnt, saturating at 16'hFFFF.
REQ-015 In TIMING, react_rise SHALL load react_time with rcnt (the pre-increment value when it coincides with a tick), pulse react_valid, and return to IDLE.
REQ-016 react_rise in ARM, SEQ or DELAY SHALL pulse jump_start and fsm_abort for one cycle and return to IDLE; react_time SHALL stay unchanged.
REQ-017 react_rise SHALL take priority over delay expiry in the same cycle, producing jump_start with no go.
REQ-018 The LFSR SHALL be 7 bits, polynomial x^7+x^6+1 with maximal length 127, seed 7'h01, advancing every cycle including IDLE, and never reaching zero.
REQ-019 Outside the conditions above, fsm_en, fsm_trigger, fsm_abort, go, jump_start and react_valid SHALL be 0.
REQ-020 A tick_div change mid-run SHALL take effect immediately; if pcnt > tick_div, pcnt SHALL count up to 16'hFFFF and wrap to 0.
REQ-021 cmd_seq SHALL be used only for the consistency check in REQ-022.
REQ-022 In SEQ, if cmd_seq=0 and cmd_delay=0 while tick, the block SHALL return to IDLE.

Reset
REQ-023 On rst, the state SHALL be IDLE; pcnt, dcnt, rcnt and react_time SHALL be 0; the LFSR SHALL be 7'h01; start_q and react_q SHALL be 0.
REQ-024 Reset SHALL take priority over all other inputs.
REQ-025 While rst is high, every output SHALL be 0.
REQ-026 rst mid-operation SHALL abandon the run with no go, react_valid or jump_start pulse.

Structure
REQ-027 The shared package f1_pkg SHALL hold the state enum, LFSR_W=7, LFSR_SEED, LFSR_TAPS and TIME_W=16.
REQ-028 The prescaler SHALL be a sub-module f1_tick (clk, rst, clr, div, tick); all other logic SHALL stay in f1_ctrl.

Verification
REQ-029 Bench case: tick_div=0, start pulse, FSM model reaches cmd_delay after 8 fsm_en -> trigger 1 cycle after start_rise; exactly 8 fsm_en before DELAY; never a 9th fsm_en while cmd_delay=1.
REQ-030 Bench case: tick_div=3, LFSR forced/known L=5 at entry -> go exactly 5*4 cycles after DELAY entry, coincident with one fsm_en.
REQ-031 Bench case: react press 37 ticks after go, tick_div=0 -> react_time=37, one react_valid pulse, busy falls next cycle.
REQ-032 Bench case: react press during SEQ; separately, react press on the same cycle as delay expiry -> jump_start and fsm_abort pulse, no go, react_time unchanged.
REQ-033 Bench case: rst asserted in DELAY; start held high across reset release -> IDLE, all outputs 0; no ARM until start drops and rises again.
REQ-034 Bench case: no react for 70000 ticks in TIMING, then react -> react_time=16'hFFFF.
